// File: rtl/enemy_pkg.sv
// Shared types and screen limits for the chasing enemy.
// Coordinates are 9-bit top-left positions.
package enemy_pkg;

   typedef enum logic [2:0] {
      ST_CHASE    = 3'd0,
      ST_KNOCK    = 3'd1,
      ST_STUN     = 3'd2,
      ST_COOLDOWN = 3'd3,
      ST_DEAD     = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      DIR_DOWN  = 2'd0,
      DIR_LEFT  = 2'd1,
      DIR_UP    = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   localparam int SCREEN_X_MIN  = 0;
   localparam int SCREEN_X_LAST = 319;
   localparam int SCREEN_Y_MIN  = 52;
   localparam int SCREEN_Y_LAST = 205;
   localparam int CNT_W         = 8;

   // DOWN<->UP and LEFT<->RIGHT differ only in bit 1
   function automatic dir_t opposite_dir(input dir_t d);
      return dir_t'(d ^ 2'b10);
   endfunction

   function automatic logic [8:0] clamp_coord(input logic signed [10:0] v,
                                              input logic signed [10:0] lo,
                                              input logic signed [10:0] hi);
      if (v < lo)
         return lo[8:0];
      else if (v > hi)
         return hi[8:0];
      else
         return v[8:0];
   endfunction

endpackage

// File: rtl/enemy_move_clamp.sv
// Moves a position by delta in one direction and saturates both axes to the
// play area; signed 11-bit math so underflow never wraps.
module enemy_move_clamp
   import enemy_pkg::*;
#(
   parameter int X_MIN = 0,
   parameter int X_MAX = 293,
   parameter int Y_MIN = 52,
   parameter int Y_MAX = 179
) (
   input  logic [8:0] pos_x,
   input  logic [8:0] pos_y,
   input  logic [8:0] delta,
   input  dir_t       dir,
   output logic [8:0] next_x,
   output logic [8:0] next_y
);

   logic signed [10:0] sum_x;
   logic signed [10:0] sum_y;
   logic signed [10:0] d;

   always_comb begin
      d     = signed'({2'b00, delta});
      sum_x = signed'({2'b00, pos_x});
      sum_y = signed'({2'b00, pos_y});
      case (dir)
         DIR_DOWN: sum_y = sum_y + d;
         DIR_UP:   sum_y = sum_y - d;
         DIR_LEFT: sum_x = sum_x - d;
         default:  sum_x = sum_x + d;
      endcase
      next_x = clamp_coord(sum_x, 11'(X_MIN), 11'(X_MAX));
      next_y = clamp_coord(sum_y, 11'(Y_MIN), 11'(Y_MAX));
   end

endmodule

// File: rtl/enemy_chaser.sv
// Enemy that walks toward the player, attacks on contact with a cooldown,
// takes knockback and stun on hits, and dies/respawns.
module enemy_chaser
   import enemy_pkg::*;
#(
   parameter int START_X         = 35,
   parameter int START_Y         = 27,
   parameter int OBJ_W           = 26,
   parameter int OBJ_H           = 26,
   parameter int PLAYER_W        = 18,
   parameter int PLAYER_H        = 20,
   parameter int STEP            = 1,
   parameter int KNOCKBACK       = 3,
   parameter int STUN_FRAMES     = 6,
   parameter int MAX_HP          = 8,
   parameter int COOLDOWN_FRAMES = 30,
   parameter int ATTACK_DIST     = 3
) (
   input  logic       game_frame_clk_rising_edge,
   input  logic       Reset,
   input  logic       freeze,
   input  logic       spawn,
   input  logic       hit,
   input  logic [3:0] damage,
   input  logic [8:0] player_x,
   input  logic [8:0] player_y,
   output logic [8:0] pos_x,
   output logic [8:0] pos_y,
   output logic [1:0] dir,
   output logic [2:0] state,
   output logic [3:0] hp,
   output logic       alive,
   output logic       attack,
   output logic [1:0] anim
);

   logic [8:0]       pos_x_reg, pos_x_next;
   logic [8:0]       pos_y_reg, pos_y_next;
   dir_t             dir_reg, dir_next;
   state_t           state_reg, state_next;
   logic [3:0]       hp_reg, hp_next;
   logic             attack_reg, attack_next;
   logic [1:0]       anim_reg, anim_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   logic [9:0] ex, ey, px, py;
   logic       move_right, move_left, move_down, move_up;
   logic       want_move, in_reach;
   dir_t       chase_dir;
   logic [3:0] hp_after_hit;
   logic [8:0] step_x, step_y, knock_x, knock_y;

   always_comb begin
      ex = {1'b0, pos_x_reg};
      ey = {1'b0, pos_y_reg};
      px = {1'b0, player_x};
      py = {1'b0, player_y};
      move_right = (ex + 10'(OBJ_W)) < px;
      move_left  = ex > (px + 10'(PLAYER_W));
      move_down  = (ey + 10'(OBJ_H)) < py;
      move_up    = ey > (py + 10'(PLAYER_H));
      want_move  = move_right | move_left | move_down | move_up;
      in_reach   = (ex <= px + 10'(PLAYER_W + ATTACK_DIST)) &&
                   (ex + 10'(OBJ_W + ATTACK_DIST) >= px) &&
                   (ey <= py + 10'(PLAYER_H + ATTACK_DIST)) &&
                   (ey + 10'(OBJ_H + ATTACK_DIST) >= py);
      if (move_right)
         chase_dir = DIR_RIGHT;
      else if (move_left)
         chase_dir = DIR_LEFT;
      else if (move_down)
         chase_dir = DIR_DOWN;
      else
         chase_dir = DIR_UP;
      hp_after_hit = (damage >= hp_reg) ? 4'd0 : hp_reg - damage;
   end

   enemy_move_clamp #(
      .X_MIN(SCREEN_X_MIN), .X_MAX(SCREEN_X_LAST - OBJ_W),
      .Y_MIN(SCREEN_Y_MIN), .Y_MAX(SCREEN_Y_LAST - OBJ_H)
   ) u_step_clamp (
      .pos_x(pos_x_reg), .pos_y(pos_y_reg), .delta(9'(STEP)), .dir(chase_dir),
      .next_x(step_x), .next_y(step_y)
   );

   enemy_move_clamp #(
      .X_MIN(SCREEN_X_MIN), .X_MAX(SCREEN_X_LAST - OBJ_W),
      .Y_MIN(SCREEN_Y_MIN), .Y_MAX(SCREEN_Y_LAST - OBJ_H)
   ) u_knock_clamp (
      .pos_x(pos_x_reg), .pos_y(pos_y_reg), .delta(9'(KNOCKBACK)),
      .dir(opposite_dir(dir_reg)),
      .next_x(knock_x), .next_y(knock_y)
   );

   // Any frame without a chase step leaves anim at 0
   always_comb begin
      pos_x_next  = pos_x_reg;
      pos_y_next  = pos_y_reg;
      dir_next    = dir_reg;
      state_next  = state_reg;
      hp_next     = hp_reg;
      attack_next = 1'b0;
      anim_next   = 2'd0;
      cnt_next    = cnt_reg;

      if (hit && state_reg != ST_DEAD) begin
         hp_next    = hp_after_hit;
         cnt_next   = '0;
         state_next = (hp_after_hit == 4'd0) ? ST_DEAD : ST_KNOCK;
      end else begin
         case (state_reg)
            ST_CHASE, ST_COOLDOWN: begin
               if (state_reg == ST_CHASE && in_reach) begin
                  attack_next = 1'b1;
                  state_next  = ST_COOLDOWN;
                  cnt_next    = '0;
               end else begin
                  if (want_move) begin
                     pos_x_next = step_x;
                     pos_y_next = step_y;
                     dir_next   = chase_dir;
                     anim_next  = (chase_dir != dir_reg) ? 2'd1 : anim_reg + 2'd1;
                  end
                  if (state_reg == ST_COOLDOWN) begin
                     if (cnt_reg == CNT_W'(COOLDOWN_FRAMES - 1)) begin
                        state_next = ST_CHASE;
                        cnt_next   = '0;
                     end else begin
                        cnt_next = cnt_reg + 1'b1;
                     end
                  end
               end
            end
            ST_KNOCK: begin
               pos_x_next = knock_x;
               pos_y_next = knock_y;
               state_next = ST_STUN;
               cnt_next   = '0;
            end
            ST_STUN: begin
               if (cnt_reg == CNT_W'(STUN_FRAMES - 1)) begin
                  state_next = ST_CHASE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            default: begin
               if (spawn) begin
                  pos_x_next = 9'(START_X);
                  pos_y_next = 9'(START_Y);
                  hp_next    = 4'(MAX_HP);
                  dir_next   = DIR_DOWN;
                  state_next = ST_CHASE;
                  cnt_next   = '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge game_frame_clk_rising_edge) begin
      if (Reset) begin
         pos_x_reg  <= 9'(START_X);
         pos_y_reg  <= 9'(START_Y);
         dir_reg    <= DIR_DOWN;
         state_reg  <= ST_CHASE;
         hp_reg     <= 4'(MAX_HP);
         attack_reg <= 1'b0;
         anim_reg   <= 2'd0;
         cnt_reg    <= '0;
      end else if (freeze) begin
         attack_reg <= 1'b0;
      end else begin
         pos_x_reg  <= pos_x_next;
         pos_y_reg  <= pos_y_next;
         dir_reg    <= dir_next;
         state_reg  <= state_next;
         hp_reg     <= hp_next;
         attack_reg <= attack_next;
         anim_reg   <= anim_next;
         cnt_reg    <= cnt_next;
      end
   end

   assign pos_x  = pos_x_reg;
   assign pos_y  = pos_y_reg;
   assign dir    = dir_reg;
   assign state  = state_reg;
   assign hp     = hp_reg;
   assign alive  = (state_reg != ST_DEAD);
   assign attack = attack_reg & ~freeze;
   assign anim   = anim_reg;

endmodule

// File: tb/tb_enemy_chaser.sv
// Directed bench for enemy_chaser: chase, attack cooldown, knockback/stun,
// death/respawn, freeze, clamping and reset.
module tb_enemy_chaser;

   logic       clk = 1'b0;
   logic       Reset, freeze, spawn, hit;
   logic [3:0] damage;
   logic [8:0] player_x, player_y;
   logic [8:0] pos_x, pos_y;
   logic [1:0] dir;
   logic [2:0] state;
   logic [3:0] hp;
   logic       alive, attack;
   logic [1:0] anim;

   int tests_run = 0;
   int tests_failed = 0;
   int gap;

   localparam int S_CHASE = 0, S_KNOCK = 1, S_STUN = 2, S_COOL = 3, S_DEAD = 4;

   always #5 clk = ~clk;

   enemy_chaser dut (
      .game_frame_clk_rising_edge(clk), .Reset(Reset), .freeze(freeze),
      .spawn(spawn), .hit(hit), .damage(damage),
      .player_x(player_x), .player_y(player_y),
      .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .state(state), .hp(hp),
      .alive(alive), .attack(attack), .anim(anim)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int got, input int exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   initial begin
      Reset = 1'b1; freeze = 1'b0; spawn = 1'b0; hit = 1'b0; damage = 4'd0;
      player_x = 9'd200; player_y = 9'd100;
      tick(); tick();
      check("rst_pos_x", pos_x, 35);
      check("rst_pos_y", pos_y, 27);
      check("rst_dir", dir, 0);
      check("rst_state", state, S_CHASE);
      check("rst_hp", hp, 8);
      check("rst_alive", alive, 1);
      check("rst_attack", attack, 0);
      check("rst_anim", anim, 0);

      // First chase step: right, y pulled into the play area
      Reset = 1'b0;
      tick();
      check("step1_x", pos_x, 36);
      check("step1_y", pos_y, 52);
      check("step1_dir", dir, 3);
      check("step1_anim", anim, 1);
      tick(); tick(); tick();
      check("step4_x", pos_x, 39);
      check("step4_anim_wrap", anim, 0);

      // Player within reach: attack strobe, no move
      player_x = 9'd67; player_y = 9'd52;
      tick();
      check("atk_pulse", attack, 1);
      check("atk_state", state, S_COOL);
      check("atk_no_move", pos_x, 39);
      tick();
      check("atk_one_frame", attack, 0);
      check("cool_chase_x", pos_x, 40);
      gap = 0;
      for (int i = 2; i <= 40; i++) begin
         tick();
         if (attack) begin
            gap = i;
            break;
         end
      end
      check("atk_gap", gap, 31);

      // Walk right to x=100, then take a hit of 3
      player_x = 9'd300; player_y = 9'd52;
      for (int i = 0; i < 200 && pos_x != 9'd100; i++) tick();
      check("reach_x100", pos_x, 100);
      check("reach_dir", dir, 3);
      hit = 1'b1; damage = 4'd3;
      tick();
      hit = 1'b0;
      check("hit_hp", hp, 5);
      check("hit_state", state, S_KNOCK);
      tick();
      check("knock_x", pos_x, 97);
      check("knock_dir", dir, 3);
      check("knock_state", state, S_STUN);
      for (int i = 0; i < 5; i++) tick();
      check("stun_hold_x", pos_x, 97);
      check("stun_last", state, S_STUN);
      tick();
      check("stun_done", state, S_CHASE);

      // Hit and attack in the same frame: hit wins
      player_x = 9'd125;
      hit = 1'b1; damage = 4'd1;
      tick();
      hit = 1'b0; player_x = 9'd300;
      check("prio_attack", attack, 0);
      check("prio_state", state, S_KNOCK);
      check("prio_hp", hp, 4);
      tick();
      check("prio_knock_x", pos_x, 94);
      tick(); tick();
      hit = 1'b1;
      tick();
      hit = 1'b0;
      check("stun_rehit_state", state, S_KNOCK);
      check("stun_rehit_hp", hp, 3);
      tick();
      check("rehit_knock_x", pos_x, 91);
      for (int i = 0; i < 5; i++) tick();
      check("rehit_stun_last", state, S_STUN);
      tick();
      check("rehit_chase", state, S_CHASE);

      // Down to 2 hp, then a lethal hit while knocked
      tick();
      hit = 1'b1; damage = 4'd1;
      tick();
      check("hp_two", hp, 2);
      damage = 4'd5;
      tick();
      hit = 1'b0;
      check("dead_hp", hp, 0);
      check("dead_state", state, S_DEAD);
      check("dead_alive", alive, 0);
      tick();
      check("dead_hold_x", pos_x, 92);
      hit = 1'b1; damage = 4'd1;
      tick();
      hit = 1'b0;
      check("dead_ignore_hp", hp, 0);
      check("dead_ignore_state", state, S_DEAD);
      spawn = 1'b1;
      tick();
      spawn = 1'b0;
      check("spawn_x", pos_x, 35);
      check("spawn_y", pos_y, 27);
      check("spawn_hp", hp, 8);
      check("spawn_state", state, S_CHASE);
      check("spawn_dir", dir, 0);

      // Freeze drops hits and holds everything
      player_x = 9'd200; player_y = 9'd100;
      freeze = 1'b1; hit = 1'b1; damage = 4'd3;
      tick();
      check("frz_x", pos_x, 35);
      check("frz_hp", hp, 8);
      check("frz_state", state, S_CHASE);
      freeze = 1'b0; hit = 1'b0;
      tick();
      check("unfrz_x", pos_x, 36);
      tick();
      check("pre_knock_x", pos_x, 37);

      // Zero-damage hits push left 3 each time until the edge
      damage = 4'd0;
      for (int k = 0; k < 12; k++) begin
         hit = 1'b1; tick();
         hit = 1'b0; tick();
      end
      check("edge_x1", pos_x, 1);
      check("edge_dir", dir, 3);
      hit = 1'b1; tick();
      hit = 1'b0; tick();
      check("edge_clamp_x0", pos_x, 0);
      check("edge_state", state, S_STUN);

      // Reset during STUN while frozen
      Reset = 1'b1; freeze = 1'b1;
      tick();
      check("rst2_x", pos_x, 35);
      check("rst2_y", pos_y, 27);
      check("rst2_state", state, S_CHASE);
      check("rst2_hp", hp, 8);
      check("rst2_dir", dir, 0);
      Reset = 1'b0; freeze = 1'b0;
      tick();
      check("rst2_attack", attack, 0);
      check("rst2_step_x", pos_x, 36);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
